hex_display_driver: RTL and testbench
=====================================

# hex_display_driver

- Drives DIGITS seven-segment displays from a packed hex value; each digit is one 4-bit nibble.
- Captures a new value on a load handshake and converts it one digit per clock through a single shared decoder into a shadow register.
- Commits all digits to the outputs at once, so a partial update never reaches the display.
- Adds leading-zero blanking and per-digit blinking. Sits between the clock/counter logic and the board's HEX display pins.

## Interface
Parameters:
- DIGITS, 4, number of displays/nibbles (1..8)
- BLINK_DIV, 25000000, clock cycles per blink half-period (≥2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  request to capture value; accepted only when ready=1
- value  in  4*DIGITS  hex digits; nibble i (bits 4i+3:4i) drives display i; display DIGITS-1 is most significant
- blank_lz  in  1  leading-zero blanking enable, sampled with value
- blink_mask  in  DIGITS  bit i=1 blinks display i; live, not sampled
- ready  out  1  high when idle and able to accept load
- segments  out  7*DIGITS  display i at bits 7i+6:7i, active-low; segment bit order: 0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle

## Operation
- Encoding (7-bit hex): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→18, A→08, b→03, C→46, d→21, E→06, F→0E, blank→7F.
- FSM states:
  - IDLE: ready=1. load=1 latches value and blank_lz, sets index=DIGITS-1, sets lead flag=1, goes to CONV.
  - CONV: ready=0. Decodes nibble[index] into shadow[index], then decrements index.
    - Blanking: if blank_lz=1, lead flag=1, nibble=0 and index≠0, the shadow digit is 7F. Otherwise the lead flag clears and the decoded pattern is stored.
    - Display 0 is never blanked.
    - After index 0 is processed, goes to COMMIT.
  - COMMIT: ready=0. Copies all shadow digits to the committed register, then goes to IDLE.
- Loads during CONV or COMMIT are ignored, not queued. value and blank_lz may change freely after acceptance.
- segments = committed pattern, except display i is forced to 7F while blink_phase=1 and blink_mask[i]=1. This is a combinational path from blink_mask to segments.
- Reset: committed and shadow registers all 7F (segments all 7F), ready=1, state IDLE, blink counter 0, blink_phase=0.
- Reset asserted mid-conversion aborts the update; nothing is committed.

## Timing
- Load accepted at rising edge k (load=1, ready=1). ready=0 from edge k through edge k+DIGITS+1.
- CONV occupies edges k+1 .. k+DIGITS; COMMIT is edge k+DIGITS+1. segments show the new value and ready=1 after edge k+DIGITS+1.
- Total latency DIGITS+1 cycles; maximum throughput one update per DIGITS+2 cycles.
- A load held high continuously is re-accepted on the first edge with ready=1.
- Blink counter runs 0..BLINK_DIV-1 and wraps to 0; blink_phase toggles on the wrap edge. Full blink period is 2*BLINK_DIV cycles.
- The blink counter free-runs and is independent of load/FSM activity.

## Configuration
- HEX_DISPLAY_BLINK_EN:
  - Defined: blink counter, blink_phase and blink_mask forcing are present as described.
  - Undefined: no counter is synthesised, blink_mask is ignored, and segments equals the committed register exactly.
- Leading-zero blanking and conversion behave identically in both builds.

## Test plan
- Reset: hold reset_n=0 mid-run, release -> segments all 7F for DIGITS=4, ready=1, and no change until a load.
- Basic update: DIGITS=4, value=12AF, blank_lz=0, load at edge k -> ready=0 for edges k..k+5; after edge k+5, displays 3..0 = 79,24,08,0E and ready=1. Displays keep their old pattern until that edge.
- Leading-zero blanking: value=0050, blank_lz=1 -> displays 3..0 = 7F,7F,12,40. value=0000, blank_lz=1 -> 7F,7F,7F,40. value=0000, blank_lz=0 -> all 40.
- Busy load ignored: load 1234, then pulse load with value=FFFF at edge k+2 -> final display 79,24,30,19. A held load after ready rises captures the current value.
- Blink: HEX_DISPLAY_BLINK_EN defined, BLINK_DIV=4, blink_mask=0001 -> display 0 alternates between its pattern and 7F every 4 cycles, other displays steady. With the macro undefined -> no alternation.
- Reset mid-conversion: assert reset_n=0 at edge k+2 of a load -> all 7F, ready=1, and the aborted value never appears.

Source files
------------

// File: rtl/hex_display_driver.sv
// rtl/hex_display_driver.sv - packed hex value to DIGITS seven-segment displays, double buffered
// Optional blinking is built only when HEX_DISPLAY_BLINK_EN is defined.
module hex_display_driver #(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  ready,
  output logic [7*DIGITS-1:0]   segments
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] value_q;
  logic                blz_q;
  logic [IW-1:0]       idx;
  logic                lead;
  logic [7*DIGITS-1:0] shadow;
  logic [7*DIGITS-1:0] committed;
  logic [3:0]          nib;
  logic [6:0]          dec;
  logic                blank_now;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h18;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Single shared decoder: select the nibble under conversion.
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) nib = value_q[4*i +: 4];
    end
  end

  assign dec       = hex7(nib);
  assign blank_now = blz_q && lead && (nib == 4'h0) && (idx != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      value_q   <= '0;
      blz_q     <= 1'b0;
      idx       <= '0;
      lead      <= 1'b0;
      shadow    <= {DIGITS{7'h7F}};
      committed <= {DIGITS{7'h7F}};
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            value_q <= value;
            blz_q   <= blank_lz;
            idx     <= IW'(DIGITS - 1);
            lead    <= 1'b1;
            ready   <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) shadow[7*i +: 7] <= blank_now ? 7'h7F : dec;
          end
          if (!blank_now) lead <= 1'b0;
          if (idx == '0) state <= COMMIT;
          else           idx   <= idx - 1'b1;
        end
        COMMIT: begin
          committed <= shadow;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int CW = $clog2(BLINK_DIV);

  logic [CW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // blink_mask is live, so this path stays combinational.
  always_comb begin
    segments = committed;
    for (int i = 0; i < DIGITS; i++) begin
      if (blink_phase && blink_mask[i]) segments[7*i +: 7] = 7'h7F;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ (BLINK_DIV > 1);
  assign segments     = committed;
`endif

endmodule

// File: tb/tb_hex_display_driver.sv
// tb/tb_hex_display_driver.sv - self-checking bench for hex_display_driver
// Follows HEX_DISPLAY_BLINK_EN the same way the design does.
module tb_hex_display_driver;

  localparam int DIGITS    = 4;
  localparam int BLINK_DIV = 4;
  localparam logic [6:0] LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic        ready;
  logic [27:0] segments;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_display_driver #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value), .blank_lz(blank_lz),
    .blink_mask(blink_mask), .ready(ready), .segments(segments)
  );

  // Display content implied by a value: blank every digit above the most significant non-zero one.
  function automatic logic [27:0] expect_disp(input logic [15:0] v, input logic blz);
    int msd;
    logic [27:0] r;
    msd = 0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] != 4'h0) msd = i;
    for (int i = 0; i < DIGITS; i++) r[7*i +: 7] = (blz && i > msd) ? 7'h7F : LUT[v[4*i +: 4]];
    return r;
  endfunction

  logic        m_ready = 1'b1;
  int          m_busy = 0;
  int          m_edges = 0;
  logic [27:0] m_disp = {4{7'h7F}};
  logic [27:0] m_pend = {4{7'h7F}};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready <= 1'b1;
      m_busy  <= 0;
      m_edges <= 0;
      m_disp  <= {4{7'h7F}};
    end else begin
      m_edges <= m_edges + 1;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_disp  <= m_pend;
          m_ready <= 1'b1;
        end
      end else if (load) begin
        m_pend  <= expect_disp(value, blank_lz);
        m_busy  <= DIGITS + 1;
        m_ready <= 1'b0;
      end
    end
  end

  function automatic logic [27:0] expect_seg();
    logic [27:0] r;
    r = m_disp;
`ifdef HEX_DISPLAY_BLINK_EN
    if (((m_edges / BLINK_DIV) % 2) == 1)
      for (int i = 0; i < DIGITS; i++) if (blink_mask[i]) r[7*i +: 7] = 7'h7F;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    checks++;
    if (segments !== expect_seg()) begin
      failures++;
      $display("FAIL model_segments t=%0t got=%h exp=%h", $time, segments, expect_seg());
    end
    checks++;
    if (ready !== m_ready) begin
      failures++;
      $display("FAIL model_ready t=%0t got=%b exp=%b", $time, ready, m_ready);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_lit(input string name, input logic [27:0] exp);
    checks++;
    if (segments !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, segments, exp);
    end
  endtask

  task automatic check_ready(input string name, input logic exp);
    checks++;
    if (ready !== exp) begin
      failures++;
      $display("FAIL %s ready got=%b exp=%b", name, ready, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_ready timeout got=%b exp=1", ready);
    end
  endtask

  task automatic do_update(input logic [15:0] v, input logic blz);
    wait_ready();
    load = 1'b1;
    value = v;
    blank_lz = blz;
    tick(1);
    load = 1'b0;
    value = ~v;
    blank_lz = ~blz;
    tick(DIGITS + 1);
  endtask

  initial begin
    logic [6:0] prev;
    int toggles;

    tick(3);
    reset_n = 1'b1;
    tick(5);
    check_lit("reset_segments", {4{7'h7F}});
    check_ready("reset", 1'b1);

    load = 1'b1; value = 16'h12AF; blank_lz = 1'b0;
    tick(1);
    load = 1'b0; value = 16'h0000;
    check_ready("basic_busy_k", 1'b0);
    tick(DIGITS);
    check_lit("basic_old_k4", {4{7'h7F}});
    check_ready("basic_busy_k4", 1'b0);
    tick(1);
    check_lit("basic_new", {7'h79, 7'h24, 7'h08, 7'h0E});
    check_ready("basic_done", 1'b1);

    do_update(16'h0050, 1'b1);
    check_lit("lz_0050", {7'h7F, 7'h7F, 7'h12, 7'h40});
    do_update(16'h0000, 1'b1);
    check_lit("lz_0000", {7'h7F, 7'h7F, 7'h7F, 7'h40});
    do_update(16'h0000, 1'b0);
    check_lit("nolz_0000", {4{7'h40}});
    do_update(16'h0F00, 1'b1);
    check_lit("lz_0F00", {7'h7F, 7'h0E, 7'h40, 7'h40});
    do_update(16'h8000, 1'b1);
    check_lit("lz_8000", {7'h00, 7'h40, 7'h40, 7'h40});

    wait_ready();
    load = 1'b1; value = 16'h1234; blank_lz = 1'b0;
    tick(1);
    load = 1'b0;
    tick(1);
    load = 1'b1; value = 16'hFFFF;
    tick(1);
    load = 1'b0;
    tick(DIGITS - 1);
    check_lit("busy_ignored", {7'h79, 7'h24, 7'h30, 7'h19});
    tick(3);
    check_lit("busy_not_queued", {7'h79, 7'h24, 7'h30, 7'h19});

    load = 1'b1; value = 16'hABCD;
    tick(1);
    value = 16'h5678;
    tick(DIGITS + 1);
    check_lit("held_first", {7'h08, 7'h03, 7'h46, 7'h21});
    tick(1);
    check_ready("held_reaccept", 1'b0);
    load = 1'b0;
    tick(DIGITS + 1);
    check_lit("held_second", {7'h12, 7'h02, 7'h78, 7'h00});

    load = 1'b1; value = 16'h9999;
    tick(1);
    load = 1'b0;
    tick(1);
    reset_n = 1'b0;
    tick(1);
    check_lit("abort_reset", {4{7'h7F}});
    check_ready("abort_reset", 1'b1);
    reset_n = 1'b1;
    tick(DIGITS + 3);
    check_lit("abort_no_commit", {4{7'h7F}});

    do_update(16'h0000, 1'b0);
    blink_mask = 4'b0001;
    prev = segments[6:0];
    toggles = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (segments[6:0] !== prev) toggles++;
      prev = segments[6:0];
      checks++;
      if (segments[27:7] !== {3{7'h40}}) begin
        failures++;
        $display("FAIL blink_steady got=%h exp=%h", segments[27:7], {3{7'h40}});
      end
    end
    checks++;
`ifdef HEX_DISPLAY_BLINK_EN
    if (toggles != 4) begin
      failures++;
      $display("FAIL blink_toggles got=%0d exp=4", toggles);
    end
`else
    if (toggles != 0) begin
      failures++;
      $display("FAIL blink_toggles got=%0d exp=0", toggles);
    end
`endif
    blink_mask = 4'b0000;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
